// File: rtl/vmem_pkg.sv
// Shared types and constants for the vector memory-access stage.
// vec_t is the register-file write-vector shape.
package vmem_pkg;

  localparam int unsigned LANES = 6;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 16;

  localparam logic [2:0] LAST_LANE = 3'(LANES - 1);

  typedef enum logic [1:0] {
    OP_LDV = 2'b00,
    OP_LDS = 2'b01,
    OP_STV = 2'b10,
    OP_RSV = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WB,
    S_STORE,
    S_FIN
  } state_t;

  typedef logic [LANES-1:0][DW-1:0] vec_t;

endpackage

// File: rtl/vec_lane_buffer.sv
// LANES x DW assembly register with indexed byte write, clear and parallel read-out.
module vec_lane_buffer
  import vmem_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          we,
  input  logic [2:0]    idx,
  input  logic [DW-1:0] wdata,
  output vec_t          data
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      data <= '0;
    end else if (we) begin
      data[idx] <= wdata;
    end
  end

endmodule

// File: rtl/vector_mem_unit.sv
// Byte-serial vector/scalar load and vector store sequencer feeding the
// vector register file write port.
module vector_mem_unit
  import vmem_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [AW-1:0]            base_addr,
  input  logic [3:0]               rd_idx,
  input  logic [LANES-1:0][DW-1:0] st_data,
  output logic [AW-1:0]            mem_addr,
  output logic                     mem_we,
  output logic [DW-1:0]            mem_wdata,
  input  logic [DW-1:0]            mem_rdata,
  output logic                     busy,
  output logic                     wb_we,
  output logic                     wb_sflag,
  output logic [3:0]               wb_addr,
  output logic [LANES-1:0][DW-1:0] wb_data,
  output logic                     done
);

  state_t        state, state_nx;
  op_t           op_q;
  logic [AW-1:0] base_q;
  logic [3:0]    rd_q;
  vec_t          st_q;
  logic [2:0]    idx;
  logic [2:0]    last_idx;
  logic          accept;

  logic          buf_we;
  logic [2:0]    buf_idx;
  vec_t          buf_data;

  // Hold registers let the address/data outputs keep their last driven value.
  logic [AW-1:0] addr_hold;
  logic [DW-1:0] wdata_hold;
  logic [3:0]    wb_addr_hold;
  vec_t          wb_data_hold;

  assign accept   = (state == S_IDLE) && start && (op_t'(op) != OP_RSV);
  assign last_idx = (op_q == OP_LDS) ? 3'd0 : LAST_LANE;

  vec_lane_buffer u_buf (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .we    (buf_we),
    .idx   (buf_idx),
    .wdata (mem_rdata),
    .data  (buf_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (accept) state_nx = (op_t'(op) == OP_STV) ? S_STORE : S_READ;
      S_READ:  if (idx == last_idx) state_nx = S_DRAIN;
      S_DRAIN: state_nx = S_WB;
      S_WB:    state_nx = S_IDLE;
      S_STORE: if (idx == LAST_LANE) state_nx = S_FIN;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q         <= OP_LDV;
      base_q       <= '0;
      rd_q         <= '0;
      st_q         <= '0;
      idx          <= '0;
      addr_hold    <= '0;
      wdata_hold   <= '0;
      wb_addr_hold <= '0;
      wb_data_hold <= '0;
    end else begin
      if (accept) begin
        op_q   <= op_t'(op);
        base_q <= base_addr;
        rd_q   <= rd_idx;
        st_q   <= st_data;
        idx    <= '0;
      end else if ((state == S_READ && idx != last_idx) ||
                   (state == S_STORE && idx != LAST_LANE)) begin
        idx <= idx + 3'd1;
      end
      addr_hold    <= mem_addr;
      wdata_hold   <= mem_wdata;
      wb_addr_hold <= wb_addr;
      wb_data_hold <= wb_data;
    end
  end

  always_comb begin
    mem_addr  = addr_hold;
    mem_wdata = wdata_hold;
    wb_addr   = wb_addr_hold;
    wb_data   = wb_data_hold;
    mem_we    = 1'b0;
    wb_we     = 1'b0;
    wb_sflag  = 1'b0;
    done      = 1'b0;
    buf_we    = 1'b0;
    buf_idx   = idx - 3'd1;
    busy      = (state != S_IDLE);
    unique case (state)
      S_READ: begin
        mem_addr = base_q + AW'(idx);
        // Read data lags the address by one cycle, so lane idx-1 lands now.
        buf_we   = (idx != 3'd0);
      end
      S_DRAIN: begin
        buf_we  = 1'b1;
        buf_idx = last_idx;
      end
      S_WB: begin
        wb_we    = 1'b1;
        done     = 1'b1;
        wb_addr  = rd_q;
        wb_data  = buf_data;
        wb_sflag = (op_q == OP_LDS);
      end
      S_STORE: begin
        mem_we    = 1'b1;
        mem_addr  = base_q + AW'(idx);
        mem_wdata = st_q[idx];
      end
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vector_mem_unit.sv
// Scoreboard bench for vector_mem_unit: directed plan cases plus random ops
// against a byte-array reference memory.
module tb_vector_mem_unit;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [1:0]        op;
  logic [15:0]       base_addr;
  logic [3:0]        rd_idx;
  logic [5:0][7:0]   st_data;
  logic [15:0]       mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              busy;
  logic              wb_we;
  logic              wb_sflag;
  logic [3:0]        wb_addr;
  logic [5:0][7:0]   wb_data;
  logic              done;

  vector_mem_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .base_addr (base_addr),
    .rd_idx    (rd_idx),
    .st_data   (st_data),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .wb_we     (wb_we),
    .wb_sflag  (wb_sflag),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  addr;
    logic [47:0] data;
    logic        sflag;
    int unsigned cyc;
  } wb_item_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int unsigned cyc;
  } wr_item_t;

  wb_item_t    wb_q[$];
  wr_item_t    wr_q[$];
  int unsigned done_q[$];

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents a write-back, store or done.
  always @(negedge clk) begin
    if (!reset) begin
      if (wb_we) begin
        if (wb_q.size() == 0) check("wb_unexpected", wb_we, 0);
        else begin
          wb_item_t it;
          it = wb_q.pop_front();
          check("wb_addr", wb_addr, it.addr);
          check("wb_data", wb_data, it.data);
          check("wb_sflag", wb_sflag, it.sflag);
          check("wb_cycle", cyc, it.cyc);
        end
      end else begin
        if (wb_sflag) check("sflag_idle", wb_sflag, 0);
      end
      if (mem_we) begin
        if (wr_q.size() == 0) check("mem_we_unexpected", mem_we, 0);
        else begin
          wr_item_t w;
          w = wr_q.pop_front();
          check("st_addr", mem_addr, w.addr);
          check("st_data", mem_wdata, w.data);
          check("st_cycle", cyc, w.cyc);
        end
      end
      if (done) begin
        if (done_q.size() == 0) check("done_unexpected", done, 0);
        else check("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) check("idle_timeout", busy, 0);
  endtask

  // Issue one request at a negedge while idle; optionally jam start with noise while busy.
  task automatic issue(input logic [1:0] o, input logic [15:0] b, input logic [3:0] r,
                       input logic [47:0] d, input bit noise);
    int unsigned a;
    logic [47:0] v;
    wait_idle();
    start = 1'b1; op = o; base_addr = b; rd_idx = r; st_data = d;
    a = cyc + 1;
    v = '0;
    case (o)
      2'b00: begin
        for (int k = 0; k < 6; k++) v[k*8 +: 8] = ref_mem[16'(b + 16'(k))];
        wb_q.push_back('{addr: r, data: v, sflag: 1'b0, cyc: a + 7});
        done_q.push_back(a + 7);
      end
      2'b01: begin
        v[7:0] = ref_mem[b];
        wb_q.push_back('{addr: r, data: v, sflag: 1'b1, cyc: a + 2});
        done_q.push_back(a + 2);
      end
      2'b10: begin
        for (int k = 0; k < 6; k++) begin
          wr_q.push_back('{addr: 16'(b + 16'(k)), data: d[k*8 +: 8], cyc: a + k});
          ref_mem[16'(b + 16'(k))] = d[k*8 +: 8];
        end
        done_q.push_back(a + 6);
      end
      default: ;
    endcase
    @(negedge clk);
    check("busy_after_start", busy, (o != 2'b11));
    if (noise) begin
      for (int n = 0; n < 20 && busy; n++) begin
        start = 1'b1;
        op = (n % 2 == 1) ? 2'b11 : 2'($urandom_range(0, 2));
        base_addr = 16'($urandom); rd_idx = 4'($urandom); st_data = {$urandom, $urandom};
        @(negedge clk);
      end
    end
    start = 1'b0;
  endtask

  logic [47:0] vec;

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; base_addr = '0; rd_idx = '0; st_data = '0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 6; i++) begin
      mem[16'h10 + i] = 8'(i + 1);
      ref_mem[16'h10 + i] = 8'(i + 1);
    end
    mem[16'h20] = 8'hAB; ref_mem[16'h20] = 8'hAB;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_wb_we", wb_we, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_done", done, 0);

    issue(2'b00, 16'h0010, 4'd3, '0, 0);
    issue(2'b01, 16'h0020, 4'd2, '0, 0);
    vec = 48'hFFEEDDCCBBAA;
    issue(2'b10, 16'hFFFE, 4'd9, vec, 0);
    issue(2'b00, 16'h0010, 4'd5, '0, 1);

    wait_idle();
    start = 1'b1; op = 2'b11;
    repeat (3) @(negedge clk);
    check("rsv_busy", busy, 0);
    start = 1'b0;

    // Reset sampled at the fourth edge of an LDV aborts it silently.
    issue(2'b00, 16'h0040, 4'd7, '0, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    wb_q.delete(); done_q.delete(); wr_q.delete();
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_wb_we", wb_we, 0);
    check("abort_wb_data", wb_data, 0);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_done", done, 0);
    issue(2'b01, 16'h0020, 4'd1, '0, 0);

    vec = {$urandom, $urandom};
    issue(2'b10, 16'h1234, 4'd0, vec, 0);
    issue(2'b00, 16'h1234, 4'd4, '0, 0);

    for (int t = 0; t < 25; t++) begin
      issue(2'($urandom_range(0, 3)),
            (t % 5 == 0) ? 16'($urandom_range(16'hFFFA, 16'hFFFF)) : 16'($urandom),
            4'($urandom), {$urandom, $urandom}, 0);
    end

    wait_idle();
    repeat (2) @(negedge clk);
    check("wb_queue_empty", wb_q.size(), 0);
    check("wr_queue_empty", wr_q.size(), 0);
    check("done_queue_empty", done_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
